seg_add_ctrl: RTL and testbench

Sequencing controller for the 7-segment adder datapath.
- Captures two operands presented as raw 7-segment patterns and routes each through the existing pattern-to-digit decoder, which is instantiated outside this block.
- Validates each decode and adds the two digits.
- Drives a time-multiplexed two-digit 7-segment display with the sum, or with an error indication.
- Sits between the operand input (switches and load button) and the display pins.

---
 rtl/seg_add_if.sv | 34 +++
 rtl/seg_add_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg_add_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_add_if.sv
// seg_add_if - operand, decoder and display signals of the 7-segment adder
// controller.
//   seg_in  [6:0] operand pattern {a..g}, sampled on load
//   load          single-cycle capture strobe
//   clr           synchronous clear to IDLE, wins over load
//   dec_seg [6:0] pattern presented to the external decoder
//   dec_val [3:0] external decoder result, combinational from dec_seg
//   busy/done/err status; sum [4:0] registered result
//   an [1:0] one-hot digit enable, seg_out [6:0] segment drive
// The slave modport is the controller; the master side is the board
// environment (switches, button, decoder, display pins).
interface seg_add_if;
    logic [6:0] seg_in;
    logic       load;
    logic       clr;
    logic [6:0] dec_seg;
    logic [3:0] dec_val;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] sum;
    logic [1:0] an;
    logic [6:0] seg_out;

    modport master (
        output seg_in, load, clr, dec_val,
        input  dec_seg, busy, done, err, sum, an, seg_out
    );

    modport slave (
        input  seg_in, load, clr, dec_val,
        output dec_seg, busy, done, err, sum, an, seg_out
    );
endinterface

// File: rtl/seg_add_ctrl.sv
// seg_add_ctrl - sequencing controller for the 7-segment adder.
// Captures two operands as raw segment patterns, checks each against the
// external pattern-to-digit decoder by re-encoding the decoded digit, adds
// the two digits and shows the sum (or E on an invalid operand) on a
// time-multiplexed two-digit display.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  seg_add_if.slave: operand input, decoder loop, status, display
// REFRESH_DIV (>= 2) sets clock cycles per displayed digit slot.
module seg_add_ctrl #(
    parameter int REFRESH_DIV = 4
) (
    input  logic      clk,
    input  logic      rst,
    seg_add_if.slave  bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] PAT_E = 7'b1001111;

    typedef enum logic [2:0] {
        S_IDLE, S_CHK_A, S_WAIT_B, S_CHK_B, S_ADD, S_SHOW, S_ERR
    } state_t;

    state_t        state, state_nx;
    logic [6:0]    opreg;
    logic [3:0]    digit_a, digit_b;
    logic [4:0]    sum_q;
    logic          done_q;
    logic [CW-1:0] cnt;
    logic          slot;          // 0 = ones digit, 1 = tens digit
    logic          dec_ok;
    logic          busy_o, err_o;
    logic [1:0]    an_o;
    logic [6:0]    seg_o;

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        case (d)
            4'd0:    digit_pattern = 7'b1111110;
            4'd1:    digit_pattern = 7'b0110000;
            4'd2:    digit_pattern = 7'b1101101;
            4'd3:    digit_pattern = 7'b1111001;
            4'd4:    digit_pattern = 7'b0110011;
            4'd5:    digit_pattern = 7'b1011011;
            4'd6:    digit_pattern = 7'b1011111;
            4'd7:    digit_pattern = 7'b1110000;
            4'd8:    digit_pattern = 7'b1111111;
            4'd9:    digit_pattern = 7'b1111011;
            default: digit_pattern = 7'b0000000;
        endcase
    endfunction

    function automatic logic [3:0] ones_digit(input logic [4:0] s);
        logic [4:0] t;
        t = (s >= 5'd10) ? s - 5'd10 : s;
        return t[3:0];
    endfunction

    // The decoder aliases blank and garbage patterns onto real digits, so an
    // operand is only trusted if the decoded digit re-encodes to exactly the
    // pattern that was presented.
    assign dec_ok = (bus.dec_val <= 4'd9) && (digit_pattern(bus.dec_val) == opreg);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    // NOTE: state_nx gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        if (bus.clr) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (bus.load) state_nx = S_CHK_A;
                S_CHK_A:  state_nx = dec_ok ? S_WAIT_B : S_ERR;
                S_WAIT_B: if (bus.load) state_nx = S_CHK_B;
                S_CHK_B:  state_nx = dec_ok ? S_ADD : S_ERR;
                S_ADD:    state_nx = S_SHOW;
                S_SHOW:   if (bus.load) state_nx = S_CHK_A;
                S_ERR:    if (bus.load) state_nx = S_CHK_A;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    // Datapath and refresh registers.
    // NOTE: these are plain flops, not a memory array, so all of them take the
    // asynchronous reset; sum and dec_seg must read 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opreg   <= '0;
            digit_a <= '0;
            digit_b <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            cnt     <= '0;
            slot    <= 1'b0;
        end else if (bus.clr) begin
            opreg   <= '0;
            digit_a <= '0;
            digit_b <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            cnt     <= '0;
            slot    <= 1'b0;
        end else begin
            // ADD always moves to SHOW when clr is low, so this marks the
            // first SHOW cycle.
            done_q <= (state == S_ADD);

            // Loads arriving in CHK_A, CHK_B or ADD are dropped.
            if (bus.load && (state inside {S_IDLE, S_WAIT_B, S_SHOW, S_ERR}))
                opreg <= bus.seg_in;

            if (state == S_CHK_A && dec_ok) digit_a <= bus.dec_val;
            if (state == S_CHK_B && dec_ok) digit_b <= bus.dec_val;
            if (state == S_ADD)             sum_q   <= {1'b0, digit_a} + {1'b0, digit_b};

            // Refresh runs only while staying in SHOW/ERR; any other cycle
            // (including the one entering SHOW/ERR) parks it at ones, count 0.
            if ((state == S_SHOW || state == S_ERR) && state_nx == state) begin
                if (cnt == CW'(REFRESH_DIV - 1)) begin
                    cnt  <= '0;
                    slot <= ~slot;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt  <= '0;
                slot <= 1'b0;
            end
        end
    end

    // Output decode from registered state, slot and sum only.
    always_comb begin
        busy_o = 1'b0;
        err_o  = 1'b0;
        an_o   = 2'b00;
        seg_o  = 7'b0000000;
        unique case (state)
            S_CHK_A, S_CHK_B, S_ADD: busy_o = 1'b1;
            S_SHOW: begin
                an_o  = slot ? 2'b10 : 2'b01;
                if (slot) seg_o = (sum_q >= 5'd10) ? digit_pattern(4'd1) : 7'b0000000;
                else      seg_o = digit_pattern(ones_digit(sum_q));
            end
            S_ERR: begin
                err_o = 1'b1;
                an_o  = slot ? 2'b10 : 2'b01;
                seg_o = slot ? 7'b0000000 : PAT_E;
            end
            default: ;
        endcase
    end

    assign bus.dec_seg = opreg;
    assign bus.busy    = busy_o;
    assign bus.done    = done_q;
    assign bus.err     = err_o;
    assign bus.sum     = sum_q;
    assign bus.an      = an_o;
    assign bus.seg_out = seg_o;
endmodule

// File: tb/tb_seg_add_ctrl.sv
// tb_seg_add_ctrl - self-checking bench for seg_add_ctrl.
// Models the external pattern-to-digit decoder (with its blank-to-0 alias),
// pushes each expected sum when the second operand is loaded and pops it
// when done pulses.
module tb_seg_add_ctrl;
    localparam int REFRESH_DIV = 4;
    localparam logic [6:0] PAT [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };
    localparam logic [6:0] PAT_E = 7'b1001111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [4:0] exp_q [$];

    seg_add_if bus ();

    seg_add_ctrl #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Decoder model: canonical patterns decode to their digit, blank aliases
    // to 0, anything else reads as 15.
    always_comb begin
        bus.dec_val = 4'hF;
        if (bus.dec_seg == 7'b0000000) bus.dec_val = 4'd0;
        for (int i = 0; i < 10; i++)
            if (bus.dec_seg == PAT[i]) bus.dec_val = 4'(i);
    end

    // Scoreboard: every done pulse consumes one expected sum.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_done: done pulsed with sum=%0d, nothing expected", bus.sum);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if (bus.sum !== e || bus.an !== 2'b01) begin
                    failures++;
                    $display("FAIL sb_sum: got sum=%0d an=%b, expected sum=%0d an=01", bus.sum, bus.an, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_op(input logic [6:0] pat);
        bus.seg_in = pat;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
    endtask

    task automatic clr_op();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.sum, bus.an, bus.seg_out, bus.dec_seg} !== '0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b err=%b sum=%0d an=%b seg=%b dec_seg=%b, expected all 0",
                     bus.busy, bus.done, bus.err, bus.sum, bus.an, bus.seg_out, bus.dec_seg);
        end
        rst = 1'b0;
        tick();
        load_op(PAT[3]);
        tick();
        load_op(PAT[4]);          // now in CHK_B
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.sum, bus.an, bus.seg_out, bus.dec_seg} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b done=%b err=%b sum=%0d an=%b seg=%b dec_seg=%b, expected all 0",
                     bus.busy, bus.done, bus.err, bus.sum, bus.an, bus.seg_out, bus.dec_seg);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.an !== 2'b00) begin
            failures++;
            $display("FAIL reset_release: got busy=%b an=%b, expected busy=0 an=00", bus.busy, bus.an);
        end
    endtask

    task automatic test_add_3_4();
        int n;
        clr_op();
        load_op(PAT[3]);
        checks++;
        if (bus.busy !== 1'b1 || bus.dec_seg !== PAT[3]) begin
            failures++;
            $display("FAIL add34_chk_a: got busy=%b dec_seg=%b, expected busy=1 dec_seg=%b", bus.busy, bus.dec_seg, PAT[3]);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.an !== 2'b00) begin
            failures++;
            $display("FAIL add34_wait_b: got busy=%b err=%b an=%b, expected 0 0 00", bus.busy, bus.err, bus.an);
        end
        exp_q.push_back(5'd7);
        load_op(PAT[4]);
        wait_done(n);
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL add34_latency: done after %0d cycles past CHK_B, expected 2", n);
        end
        checks++;
        if (bus.an !== 2'b01 || bus.seg_out !== PAT[7]) begin
            failures++;
            $display("FAIL add34_ones: got an=%b seg=%b, expected an=01 seg=%b", bus.an, bus.seg_out, PAT[7]);
        end
        repeat (REFRESH_DIV) tick();
        checks++;
        if (bus.an !== 2'b10 || bus.seg_out !== 7'b0000000) begin
            failures++;
            $display("FAIL add34_tens: got an=%b seg=%b, expected an=10 seg=0000000", bus.an, bus.seg_out);
        end
    endtask

    task automatic test_show_reload();
        int n;
        load_op(PAT[2]);
        checks++;
        if (bus.busy !== 1'b1 || bus.sum !== 5'd7) begin
            failures++;
            $display("FAIL reload_chk_a: got busy=%b sum=%0d, expected busy=1 sum=7", bus.busy, bus.sum);
        end
        tick();
        exp_q.push_back(5'd8);
        load_op(PAT[6]);
        checks++;
        if (bus.sum !== 5'd7 || bus.an !== 2'b00) begin
            failures++;
            $display("FAIL reload_hold: got sum=%0d an=%b, expected sum=7 an=00", bus.sum, bus.an);
        end
        wait_done(n);
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL reload_latency: done after %0d cycles past CHK_B, expected 2", n);
        end
    endtask

    task automatic test_refresh_9_9();
        int n;
        clr_op();
        load_op(PAT[9]);
        tick();
        exp_q.push_back(5'd18);
        load_op(PAT[9]);
        wait_done(n);
        for (int i = 0; i < 2 * REFRESH_DIV; i++) begin
            logic [1:0] ea;
            logic [6:0] es;
            ea = (i < REFRESH_DIV) ? 2'b01 : 2'b10;
            es = (i < REFRESH_DIV) ? PAT[8] : PAT[1];
            checks++;
            if (bus.an !== ea || bus.seg_out !== es || bus.done !== (i == 0)) begin
                failures++;
                $display("FAIL refresh99 cycle %0d: got an=%b seg=%b done=%b, expected an=%b seg=%b done=%b",
                         i, bus.an, bus.seg_out, bus.done, ea, es, (i == 0));
            end
            tick();
        end
        checks++;
        if (bus.an !== 2'b01 || bus.sum !== 5'd18) begin
            failures++;
            $display("FAIL refresh99_wrap: got an=%b sum=%0d, expected an=01 sum=18", bus.an, bus.sum);
        end
    endtask

    task automatic test_err();
        int n;
        load_op(7'b0000000);      // blank decodes to 0 but does not re-encode
        tick();
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.an !== 2'b01 ||
            bus.seg_out !== PAT_E || bus.sum !== 5'd18) begin
            failures++;
            $display("FAIL err_blank: got err=%b busy=%b an=%b seg=%b sum=%0d, expected 1 0 01 %b 18",
                     bus.err, bus.busy, bus.an, bus.seg_out, bus.sum, PAT_E);
        end
        repeat (REFRESH_DIV) tick();
        checks++;
        if (bus.err !== 1'b1 || bus.an !== 2'b10 || bus.seg_out !== 7'b0000000) begin
            failures++;
            $display("FAIL err_tens: got err=%b an=%b seg=%b, expected 1 10 0000000", bus.err, bus.an, bus.seg_out);
        end
        load_op(PAT[5]);
        checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL err_recover: got err=%b busy=%b, expected err=0 busy=1", bus.err, bus.busy);
        end
        tick();
        load_op(7'b1010101);      // garbage operand B
        tick();
        checks++;
        if (bus.err !== 1'b1 || bus.sum !== 5'd18 || bus.seg_out !== PAT_E) begin
            failures++;
            $display("FAIL err_garbage_b: got err=%b sum=%0d seg=%b, expected 1 18 %b", bus.err, bus.sum, bus.seg_out, PAT_E);
        end
        load_op(PAT[1]);
        tick();
        exp_q.push_back(5'd3);
        load_op(PAT[2]);
        wait_done(n);
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL err_then_add_latency: done after %0d cycles, expected 2", n);
        end
    endtask

    task automatic test_load_ignored();
        clr_op();
        load_op(PAT[3]);
        tick();
        exp_q.push_back(5'd7);
        load_op(PAT[4]);          // now in CHK_B
        bus.seg_in = PAT[8];
        bus.load   = 1'b1;
        tick();                   // load seen in CHK_B, now ADD
        bus.seg_in = PAT[9];
        tick();                   // load seen in ADD, now SHOW
        bus.load   = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.an !== 2'b01 || bus.seg_out !== PAT[7]) begin
            failures++;
            $display("FAIL ignored_show: got done=%b an=%b seg=%b, expected 1 01 %b", bus.done, bus.an, bus.seg_out, PAT[7]);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.an !== 2'b01 || bus.sum !== 5'd7) begin
            failures++;
            $display("FAIL ignored_hold: got done=%b busy=%b an=%b sum=%0d, expected 0 0 01 7",
                     bus.done, bus.busy, bus.an, bus.sum);
        end
    endtask

    task automatic test_clr_with_load();
        load_op(PAT[3]);
        tick();                   // WAIT_B
        checks++;
        if (bus.sum !== 5'd7) begin
            failures++;
            $display("FAIL clr_pre_sum: got sum=%0d, expected 7", bus.sum);
        end
        bus.clr    = 1'b1;
        bus.load   = 1'b1;
        bus.seg_in = PAT[4];
        tick();
        bus.clr    = 1'b0;
        bus.load   = 1'b0;
        checks++;
        if (bus.sum !== 5'd0 || bus.busy !== 1'b0 || bus.dec_seg !== 7'b0 || bus.an !== 2'b00) begin
            failures++;
            $display("FAIL clr_load: got sum=%0d busy=%b dec_seg=%b an=%b, expected 0 0 0000000 00",
                     bus.sum, bus.busy, bus.dec_seg, bus.an);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL clr_idle: got busy=%b err=%b, expected 0 0", bus.busy, bus.err);
        end
    endtask

    initial begin
        bus.seg_in = '0;
        bus.load   = 1'b0;
        bus.clr    = 1'b0;
        test_reset();
        test_add_3_4();
        test_show_reload();
        test_refresh_9_9();
        test_err();
        test_load_ignored();
        test_clr_with_load();
        repeat (2) tick();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d expected sums never produced, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
